// File: rtl/shift_arbiter_if.sv
// Bus between shift_arbiter, its requesters, the shared shifter and the response consumer.
// master = arbiter side, slave = environment side (requesters, shifter, consumer).
interface shift_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_data;
   logic [5*NUM_REQ-1:0]  req_shamt;
   logic [NUM_REQ-1:0]    req_fill;

   logic [31:0]           sh_data;
   logic [4:0]            sh_shamt;
   logic                  sh_shift_in;
   logic [31:0]           sh_result;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic [ID_W-1:0]       rsp_id;
   logic [15:0]           stall_cnt;

   modport master (
      input  req_valid, req_data, req_shamt, req_fill, sh_result, rsp_ready,
      output req_ready, sh_data, sh_shamt, sh_shift_in, rsp_valid, rsp_data, rsp_id, stall_cnt
   );

   modport slave (
      output req_valid, req_data, req_shamt, req_fill, sh_result, rsp_ready,
      input  req_ready, sh_data, sh_shamt, sh_shift_in, rsp_valid, rsp_data, rsp_id, stall_cnt
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational left shifter among NUM_REQ requesters.
// Define SHIFT_ARB_STALL_CNT_EN to build the saturating response-backpressure counter.
module shift_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic           clock,
   input  logic           reset,
   shift_arbiter_if.master bus
);
   localparam int unsigned CW = ID_W + 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          state_q, state_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic            found;
   logic [ID_W-1:0] grant;
   logic [CW-1:0]   cand_w;
   logic [ID_W-1:0] cand;
   logic            can_accept;
   logic            accept;

   // One extra bit on the candidate sum lets the wrap work for non-power-of-two NUM_REQ.
   always_comb begin
      found  = 1'b0;
      grant  = '0;
      cand_w = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand_w = {1'b0, rr_ptr_q} + CW'(k);
         if (cand_w >= CW'(NUM_REQ)) begin
            cand_w = cand_w - CW'(NUM_REQ);
         end
         cand = cand_w[ID_W-1:0];
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
   assign accept     = found && can_accept && !reset;

   always_comb begin
      bus.req_ready   = '0;
      bus.sh_data     = '0;
      bus.sh_shamt    = '0;
      bus.sh_shift_in = 1'b0;
      if (found) begin
         bus.sh_data     = bus.req_data[32*grant +: 32];
         bus.sh_shamt    = bus.req_shamt[5*grant +: 5];
         bus.sh_shift_in = bus.req_fill[grant];
      end
      if (accept) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rr_ptr_d   = rr_ptr_q;
      if (accept) begin
         state_d    = FULL;
         rsp_data_d = bus.sh_result;
         rsp_id_d   = grant;
         rr_ptr_d   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end else if ((state_q == FULL) && bus.rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign bus.rsp_valid = (state_q == FULL);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == FULL) && !bus.rsp_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_shift_arbiter;
   localparam int NR = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   shift_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

   shift_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;

   // External shifter: concatenate fill bits below the operand and take the top word.
   function automatic logic [31:0] shifter(input logic [31:0] d, input logic [4:0] s, input logic f);
      logic [63:0] t;
      t = {d, {32{f}}} << s;
      return t[63:32];
   endfunction

   assign bus.sh_result = shifter(bus.sh_data, bus.sh_shamt, bus.sh_shift_in);

   // Reference result built from shift plus low-bit mask.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input bit f);
      logic [63:0] m;
      m = f ? ((64'd1 << s) - 64'd1) : 64'd0;
      return (d << s) | m[31:0];
   endfunction

   bit          rv [NR];
   logic [31:0] rd [NR];
   logic [4:0]  rs [NR];
   bit          rf [NR];
   bit          rr;

   int          m_ptr;
   bit          m_full;
   logic [31:0] m_data;
   int          m_id;
   int          m_stall;
   int          last_g;

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i]         = rv[i];
         bus.req_data[32*i +: 32] = rd[i];
         bus.req_shamt[5*i +: 5]  = rs[i];
         bus.req_fill[i]          = rf[i];
      end
      bus.rsp_ready = rr;
   endtask

   function automatic int winner();
      for (int k = 0; k < NR; k++) begin
         if (rv[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] exp_ready();
      int g;
      g = winner();
      if (reset || g < 0 || (m_full && !rr)) return '0;
      return NR'(1 << g);
   endfunction

   function automatic logic [15:0] exp_stall();
`ifdef SHIFT_ARB_STALL_CNT_EN
      return 16'(m_stall);
`else
      return 16'd0;
`endif
   endfunction

   task automatic model_clear();
      m_ptr   = 0;
      m_full  = 0;
      m_data  = '0;
      m_id    = 0;
      m_stall = 0;
      last_g  = -1;
   endtask

   // Advance one clock and update the model from the inputs held across the edge.
   task automatic step();
      int g;
      bit acc;
      bit was_full;
      g        = winner();
      was_full = m_full;
      acc      = (g >= 0) && (!m_full || rr);
      @(posedge clock);
      #1;
      if (was_full && !rr && m_stall < 65535) m_stall++;
      if (acc) begin
         m_data = ref_shift(rd[g], rs[g], rf[g]);
         m_id   = g;
         m_full = 1;
         m_ptr  = (g + 1) % NR;
         last_g = g;
      end else begin
         last_g = -1;
         if (was_full && rr) m_full = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      model_clear();
      reset = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NR; i++) begin
         rv[i] = 0; rd[i] = '0; rs[i] = '0; rf[i] = 0;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NR; i++) begin
         rv[i] = 1; rd[i] = $urandom; rs[i] = 5'($urandom); rf[i] = 1'($urandom);
      end
      rr = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
      else passed++;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== 35'd0)
         $display("FAIL reset_rsp: got v=%b d=%h id=%0d want all zero", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      else passed++;
      checks++;
      if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt);
      else passed++;
      clear_reqs();
      drive();
      model_clear();
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.sh_shift_in, bus.sh_shamt, bus.sh_data} !== 38'd0)
         $display("FAIL idle_sh_drive: got fill=%b shamt=%0d data=%h want zeros", bus.sh_shift_in, bus.sh_shamt, bus.sh_data);
      else passed++;
      checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL idle_req_ready: got %b want 0000", bus.req_ready);
      else passed++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_single();
      rv[1] = 1; rd[1] = 32'h0000_00F1; rs[1] = 5'd4; rf[1] = 0;
      rr = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", bus.req_ready);
      else passed++;
      step();
      rv[1] = 0;
      drive();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 32'h0000_0F10, 2'd1})
         $display("FAIL single_rsp: got v=%b d=%h id=%0d want v=1 d=00000f10 id=1", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      else passed++;
   endtask

   task automatic test_fill_max();
      rv[0] = 1; rd[0] = 32'h8000_0001; rs[0] = 5'd31; rf[0] = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) $display("FAIL fill_ready: got %b want 0001", bus.req_ready);
      else passed++;
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 32'hFFFF_FFFF, 2'd0})
         $display("FAIL fill_max_rsp: got v=%b d=%h id=%0d want v=1 d=ffffffff id=0", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      else passed++;
      rs[0] = 5'd0;
      drive();
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h8000_0001})
         $display("FAIL shamt0_rsp: got v=%b d=%h want v=1 d=80000001", bus.rsp_valid, bus.rsp_data);
      else passed++;
      rv[0] = 0;
      drive();
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NR; i++) begin
         rv[i] = 1; rd[i] = $urandom; rs[i] = 5'($urandom); rf[i] = 1'($urandom);
      end
      rr = 1;
      drive();
      for (int k = 0; k < 8; k++) begin
         step();
         checks++;
         if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'(k % NR)} || bus.rsp_data !== m_data)
            $display("FAIL rr_seq[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                     k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % NR, m_data);
         else passed++;
         if (last_g >= 0) begin
            rd[last_g] = $urandom; rs[last_g] = 5'($urandom); rf[last_g] = 1'($urandom);
         end
         drive();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held_d;
      logic [1:0]  held_id;
      held_d  = bus.rsp_data;
      held_id = bus.rsp_id;
      rr = 0;
      drive();
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (bus.req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.req_ready);
         else passed++;
         step();
         checks++;
         if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, held_d, held_id})
            $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                     k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, held_d, held_id);
         else passed++;
      end
      checks++;
`ifdef SHIFT_ARB_STALL_CNT_EN
      if (bus.stall_cnt !== 16'd5) $display("FAIL bp_stall: got %0d want 5", bus.stall_cnt);
`else
      if (bus.stall_cnt !== 16'd0) $display("FAIL bp_stall: got %0d want 0", bus.stall_cnt);
`endif
      else passed++;
      rr = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) $display("FAIL bp_release_ready: got %b want 0001", bus.req_ready);
      else passed++;
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd0} || bus.rsp_data !== m_data)
         $display("FAIL bp_release_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_data);
      else passed++;
   endtask

   task automatic test_ptr_retention();
      do_reset();
      clear_reqs();
      rv[1] = 1; rd[1] = $urandom; rs[1] = 5'd3;
      rr = 1;
      drive();
      step();
      rv[1] = 0; rv[0] = 1; rd[0] = $urandom; rs[0] = 5'd7; rf[0] = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) $display("FAIL ptr_only0_ready: got %b want 0001", bus.req_ready);
      else passed++;
      step();
      checks++;
      if (bus.rsp_id !== 2'd0 || bus.rsp_data !== m_data)
         $display("FAIL ptr_only0_rsp: got id=%0d d=%h want id=0 d=%h", bus.rsp_id, bus.rsp_data, m_data);
      else passed++;
      rv[0] = 1; rd[0] = $urandom;
      rv[1] = 1; rd[1] = $urandom; rs[1] = 5'd12; rf[1] = 0;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) $display("FAIL ptr_pair_ready: got %b want 0010", bus.req_ready);
      else passed++;
      step();
      checks++;
      if (bus.rsp_id !== 2'd1 || bus.rsp_data !== ref_shift(rd[1], 5'd12, 1'b0))
         $display("FAIL ptr_pair_rsp: got id=%0d d=%h want id=1 d=%h", bus.rsp_id, bus.rsp_data, ref_shift(rd[1], 5'd12, 1'b0));
      else passed++;
   endtask

   task automatic test_random();
      int g;
      logic [37:0] exp_sh;
      do_reset();
      clear_reqs();
      for (int c = 0; c < 400; c++) begin
         rr = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NR; i++) begin
            if (!rv[i] && $urandom_range(0, 1) == 1) begin
               rv[i] = 1;
               rd[i] = $urandom;
               case ($urandom_range(0, 3))
                  0:       rs[i] = 5'd0;
                  1:       rs[i] = 5'd31;
                  default: rs[i] = 5'($urandom);
               endcase
               rf[i] = 1'($urandom);
            end
         end
         drive();
         #1;
         g      = winner();
         exp_sh = (g >= 0) ? {1'(rf[g]), rs[g], rd[g]} : 38'd0;
         checks++;
         if (bus.req_ready !== exp_ready()) $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.req_ready, exp_ready());
         else passed++;
         checks++;
         if ({bus.sh_shift_in, bus.sh_shamt, bus.sh_data} !== exp_sh)
            $display("FAIL rnd_sh_drive[%0d]: got %h want %h", c, {bus.sh_shift_in, bus.sh_shamt, bus.sh_data}, exp_sh);
         else passed++;
         step();
         checks++;
         if (bus.rsp_valid !== m_full) $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.rsp_valid, m_full);
         else passed++;
         if (m_full) begin
            checks++;
            if (bus.rsp_data !== m_data || bus.rsp_id !== 2'(m_id))
               $display("FAIL rnd_rsp[%0d]: got d=%h id=%0d want d=%h id=%0d", c, bus.rsp_data, bus.rsp_id, m_data, m_id);
            else passed++;
         end
         checks++;
         if (bus.stall_cnt !== exp_stall()) $display("FAIL rnd_stall[%0d]: got %0d want %0d", c, bus.stall_cnt, exp_stall());
         else passed++;
         if (last_g >= 0) rv[last_g] = 0;
      end
   endtask

   task automatic test_async_reset();
      clear_reqs();
      rv[2] = 1; rd[2] = $urandom; rs[2] = 5'd9; rf[2] = 1;
      rr = 0;
      drive();
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1) $display("FAIL areset_pre_full: got %b want 1", bus.rsp_valid);
      else passed++;
      rv[2] = 0;
      drive();
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready} !== 39'd0)
         $display("FAIL areset_clear: got v=%b d=%h id=%0d rdy=%b want all zero",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      else passed++;
      #1;
      model_clear();
      reset = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rv[i] = 1; rd[i] = $urandom; rs[i] = 5'($urandom); rf[i] = 1'($urandom);
      end
      rr = 1;
      drive();
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) $display("FAIL areset_first_ready: got %b want 0001", bus.req_ready);
      else passed++;
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd0} || bus.rsp_data !== m_data)
         $display("FAIL areset_first_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_data);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_reqs();
      rr = 0;
      model_clear();
      drive();
      #12;
      test_reset();
      test_single();
      test_fill_max();
      test_round_robin();
      test_backpressure();
      test_ptr_retention();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external combinational 32-bit left barrel shifter between NUM_REQ requesters.
- Accepts shift requests over per-requester valid/ready handshakes and drives the shared shifter's data, amount and fill inputs.
- Captures the shifter result into a single-entry output register and returns it with the winning requester's ID under a valid/ready response handshake.
- Sits between ALU-side clients (for example, the shift-immediate path and the address-scaling path) and the single shifter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_data  input  32*NUM_REQ  operand; requester i occupies bits [32i+31:32i]
- req_shamt  input  5*NUM_REQ  shift amount; requester i occupies bits [5i+4:5i]
- req_fill  input  NUM_REQ  fill bit shifted into the LSBs
- sh_data  output  32  to shifter data input
- sh_shamt  output  5  to shifter shift-amount input
- sh_shift_in  output  1  to shifter fill input
- sh_result  input  32  from shifter result (combinational)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_data  output  32  registered shift result
- rsp_id  output  ID_W  index of the requester served
- stall_cnt  output  16  response backpressure cycle count (see Optional Feature)

Behaviour:
- Reset (async, active-high): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, stall_cnt=0. req_ready is combinationally 0 while reset is asserted.
- Output register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL and rsp_ready). This allows back-to-back throughput of one request per cycle.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr and wrapping modulo NUM_REQ.
  - The first set bit is the winner g.
  - req_ready[g] = can_accept; all other bits are 0.
  - With no valid request, req_ready=0.
- Shifter drive (combinational):
  - With a winner: sh_data / sh_shamt / sh_shift_in = requester g's fields.
  - With no winner: sh_data, sh_shamt and sh_shift_in are all 0.
- Transfer (requester g is accepted):
  - Occurs when req_valid[g] and req_ready[g] are both high at the clock edge.
  - rsp_data <= sh_result, rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept edge to rsp_valid=1.
- Drain without a new accept: if FULL, rsp_ready=1 and no transfer occurs, then rsp_valid <= 0.
- FULL with rsp_ready=0: rsp_valid, rsp_data and rsp_id hold stable; req_ready=0.
- rr_ptr changes only on a transfer. An idle requester does not lose its turn.
- Requester rule: once req_valid[i]=1 it holds valid and its fields stable until accepted. The arbiter does not depend on this for correctness but the bench checks it.
- Fairness: any continuously valid requester is served within NUM_REQ accepts.
- shamt=0: result equals data. The fill bit is irrelevant.
- Reset mid-operation: any pending response is dropped and rr_ptr returns to 0. No partial state survives.
- Requester indices >= NUM_REQ do not exist.

Optional Feature:
- Macro: SHIFT_ARB_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with rsp_valid=1 and rsp_ready=0.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are present.

Test Plan:
1. Single request: req 1 valid, data=32'h0000_00F1, shamt=4, fill=0, rsp_ready=1 -> req_ready=4'b0010 in the same cycle. Next cycle rsp_valid=1, rsp_data=32'h0000_0F10, rsp_id=1.
2. Fill and max shift: req 0 with data=32'h8000_0001, shamt=31, fill=1 -> rsp_data=32'hFFFF_FFFF. Then shamt=0, fill=1 -> rsp_data=32'h8000_0001.
3. Round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,… with one response per cycle and no gaps.
4. Backpressure: hold rsp_ready=0 for 5 cycles with rsp_valid=1 ->
   - rsp_data and rsp_id stay stable and req_ready=0.
   - With SHIFT_ARB_STALL_CNT_EN, stall_cnt=5; without it, stall_cnt=0.
   - Releasing rsp_ready accepts the next request on that same edge.
5. Pointer retention: rr_ptr=2 with only req 0 valid -> req 0 is served and rr_ptr becomes 1. Then reqs 0 and 1 both valid -> req 1 is served first.
6. Async reset while FULL (asserted between clock edges) -> rsp_valid=0, rsp_data=0 and rsp_id=0 immediately. After release, requester 0 wins first.
